// File: rtl/uart_dmem_loader.sv
// rtl/uart_dmem_loader.sv - UART byte stream to data-memory word loader
// Optional even-parity framing: define UART_LOADER_PARITY_EN.
module uart_dmem_loader #(
   parameter int N            = 8,
   parameter int R            = 6,
   parameter int AW           = 32,
   parameter int CLKS_PER_BIT = 217,
   parameter int WORDS        = 10930
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx,
   input  logic                enable,
   output logic                WE,
   output logic [AW-1:0]       A,
   output logic [R-1:0][N-1:0] WD,
   output logic                busy,
   output logic                done,
   output logic                frame_err,
`ifdef UART_LOADER_PARITY_EN
   output logic                parity_err,
`endif
   output logic [AW-1:0]       word_count
);

`ifdef UART_LOADER_PARITY_EN
   localparam int NB = N + 1;
`else
   localparam int NB = N;
`endif
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(NB + 1);
   localparam int LW = (R > 1) ? $clog2(R) : 1;

   localparam logic [CW-1:0] CPB_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(NB - 1);
   localparam logic [LW-1:0] LANE_LAST  = LW'(R - 1);
   localparam logic [AW-1:0] WORDS_LAST = AW'(WORDS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic                rx_s1_q, rx_s2_q, rx_prev_q;
   logic [2:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [NB-1:0]       shift_q, shift_d;
   logic [LW-1:0]       lane_idx_q;
   logic [R-1:0][N-1:0] lanes_q, lanes_d;
   logic [R-1:0][N-1:0] wd_q;
   logic [AW-1:0]       a_q, wc_q;
   logic                we_q, done_q, frame_err_q;
   logic                byte_ok, frame_set;
`ifdef UART_LOADER_PARITY_EN
   logic                parity_err_q, parity_set;
`endif

   assign WE         = we_q;
   assign A          = a_q;
   assign WD         = wd_q;
   assign done       = done_q;
   assign busy       = enable & ~done_q;
   assign frame_err  = frame_err_q;
   assign word_count = wc_q;
`ifdef UART_LOADER_PARITY_EN
   assign parity_err = parity_err_q;
`endif

   // Receive FSM next state: bit timing, serial shift and end-of-frame verdict
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      shift_d   = shift_q;
      byte_ok   = 1'b0;
      frame_set = 1'b0;
`ifdef UART_LOADER_PARITY_EN
      parity_set = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (enable && !done_q && rx_prev_q && !rx_s2_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               // A high level at mid start bit was only a glitch
               state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CPB_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s2_q, shift_q[NB-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (cnt_q == CPB_LAST) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  state_d = S_IDLE;
`ifdef UART_LOADER_PARITY_EN
                  // Even parity: data bits plus parity bit must XOR to zero
                  if (^shift_q) begin
                     parity_set = 1'b1;
                  end else begin
                     byte_ok = !done_q;
                  end
`else
                  byte_ok = !done_q;
`endif
               end else begin
                  frame_set = 1'b1;
                  state_d   = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s2_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Merge the just-received byte into the lane it belongs to
   always_comb begin
      lanes_d             = lanes_q;
      lanes_d[lane_idx_q] = shift_q[N-1:0];
   end

   // Synchronizer, FSM state, word packing and memory write strobe
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         lane_idx_q  <= '0;
         lanes_q     <= '0;
         wd_q        <= '0;
         a_q         <= '0;
         wc_q        <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         if (!enable) begin
            // Abort: drop everything in progress; A/WD keep their last values
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            lane_idx_q  <= '0;
            lanes_q     <= '0;
            wc_q        <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            we_q    <= 1'b0;
            if (frame_set) begin
               frame_err_q <= 1'b1;
            end
`ifdef UART_LOADER_PARITY_EN
            if (parity_set) begin
               parity_err_q <= 1'b1;
            end
`endif
            if (byte_ok) begin
               lanes_q <= lanes_d;
               if (lane_idx_q == LANE_LAST) begin
                  // Word complete: A shows this word's address while the
                  // count already reflects it, so done coincides with WE
                  lane_idx_q <= '0;
                  we_q       <= 1'b1;
                  wd_q       <= lanes_d;
                  a_q        <= wc_q;
                  wc_q       <= wc_q + 1'b1;
                  if (wc_q == WORDS_LAST) begin
                     done_q <= 1'b1;
                  end
               end else begin
                  lane_idx_q <= lane_idx_q + 1'b1;
               end
            end
         end
      end
   end

endmodule
